// File: rtl/port_bank_pkg.sv
// Shared definitions for the MMIO port bank: control-register offsets and edge-select encoding.
package port_bank_pkg;

  // Word offsets of the control registers, counted from NUM_PORTS (the DATA words come first).
  localparam int OFF_IRQ_EN    = 0;
  localparam int OFF_IRQ_STAT  = 1;
  localparam int OFF_EDGE_MODE = 2;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_mode_e;

endpackage

// File: rtl/mmio_port_bank_sync_edge.sv
// Per-channel interrupt event detector: 2-flop synchroniser, history flop and edge select.
// The history is only compared once it holds a real synchronised sample, so nothing fires after reset.
module sync_edge
  import port_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_i,
  input  edge_mode_e mode_i,
  output logic       evt_o
);

  logic       s1_q;
  logic       s2_q;
  logic       hist_q;
  logic       primed_q;
  logic [1:0] vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      hist_q   <= 1'b0;
      vld_q    <= 2'b00;
      primed_q <= 1'b0;
    end else begin
      s1_q     <= d_i;
      s2_q     <= s1_q;
      hist_q   <= s2_q;
      vld_q    <= {vld_q[0], 1'b1};
      primed_q <= vld_q[1];
    end
  end

  always_comb begin
    evt_o = 1'b0;
    if (primed_q) begin
      if (mode_i == EDGE_RISE) evt_o = s2_q & ~hist_q;
      else                     evt_o = ~s2_q & hist_q;
    end
  end

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of output latches, synchronised inputs and edge-triggered interrupts.
// Word map: DATA[0..NUM_PORTS-1], IRQ_EN, IRQ_STAT (write-1-to-clear), EDGE_MODE.
module mmio_port_bank
  import port_bank_pkg::*;
#(
  parameter int          NUM_PORTS = 4,
  parameter int          PORT_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h7E0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  input  logic                          we,
  input  logic                          re,
  output logic                          hit,
  output logic [31:0]                   rdata,
  input  logic [NUM_PORTS*PORT_W-1:0]   in_port,
  output logic [NUM_PORTS*PORT_W-1:0]   out_port,
  input  logic [NUM_PORTS-1:0]          irq_src,
  output logic                          irq
);

  localparam logic [29:0] WOFF_EN   = 30'(NUM_PORTS + OFF_IRQ_EN);
  localparam logic [29:0] WOFF_STAT = 30'(NUM_PORTS + OFF_IRQ_STAT);
  localparam logic [29:0] WOFF_MODE = 30'(NUM_PORTS + OFF_EDGE_MODE);

  logic [NUM_PORTS*PORT_W-1:0] out_q, out_d;
  logic [NUM_PORTS*PORT_W-1:0] in_s1_q, in_s2_q;
  logic [NUM_PORTS-1:0]        en_q, en_d;
  logic [NUM_PORTS-1:0]        stat_q, stat_d;
  logic [NUM_PORTS-1:0]        mode_q, mode_d;
  logic [NUM_PORTS-1:0]        clr;
  logic [NUM_PORTS-1:0]        evt;
  logic [29:0]                 word_off;
  logic                        unused_bits;

  assign word_off    = addr[31:2] - BASE_ADDR[31:2];
  assign hit         = (addr[31:2] >= BASE_ADDR[31:2]) && (word_off <= WOFF_MODE);
  assign unused_bits = ^{addr[1:0], wdata};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_sync
    sync_edge u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .d_i    (irq_src[g]),
      .mode_i (edge_mode_e'(mode_q[g])),
      .evt_o  (evt[g])
    );
  end

  always_comb begin
    out_d  = out_q;
    en_d   = en_q;
    mode_d = mode_q;
    clr    = '0;
    if (hit && we) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (word_off == 30'(k)) out_d[k*PORT_W +: PORT_W] = wdata[PORT_W-1:0];
      end
      if (word_off == WOFF_EN)   en_d   = wdata[NUM_PORTS-1:0];
      if (word_off == WOFF_STAT) clr    = wdata[NUM_PORTS-1:0];
      if (word_off == WOFF_MODE) mode_d = wdata[NUM_PORTS-1:0];
    end
    // A fresh event beats a same-cycle clear.
    stat_d = (stat_q & ~clr) | evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      in_s1_q <= '0;
      in_s2_q <= '0;
      en_q    <= '0;
      stat_q  <= '0;
      mode_q  <= '0;
    end else begin
      out_q   <= out_d;
      in_s1_q <= in_port;
      in_s2_q <= in_s1_q;
      en_q    <= en_d;
      stat_q  <= stat_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && re) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (word_off == 30'(k)) rdata = 32'(in_s2_q[k*PORT_W +: PORT_W]);
      end
      if (word_off == WOFF_EN)   rdata = 32'(en_q);
      if (word_off == WOFF_STAT) rdata = 32'(stat_q);
      if (word_off == WOFF_MODE) rdata = 32'(mode_q);
    end
  end

  assign out_port = out_q;
  assign irq      = |(stat_q & en_q);

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank with default parameters (4 x 8-bit ports at 0x7E0).
module tb_mmio_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic [3:0]  irq_src;
  logic        irq;

  int n_cmp = 0;
  int n_mis = 0;

  mmio_port_bank #(.NUM_PORTS(4), .PORT_W(8), .BASE_ADDR(32'h7E0)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .hit      (hit),
    .rdata    (rdata),
    .in_port  (in_port),
    .out_port (out_port),
    .irq_src  (irq_src),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    re   = 1'b1;
    #1;
    check(tag, rdata, exp);
    re   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    addr    = 32'h0;
    wdata   = 32'h0;
    we      = 1'b0;
    re      = 1'b0;
    in_port = 32'h0;
    irq_src = 4'h0;
    #2;
    check("reset_out_port", out_port, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // DATA[2] write, upper data bits dropped
    addr = 32'h7E8; wdata = 32'h1A5; we = 1'b1;
    #1;
    check("hit_data2", {31'h0, hit}, 32'h1);
    tick();
    we = 1'b0;
    check("out_port_ch2", out_port, 32'h00A5_0000);

    // writes that must not land
    wr(32'h800, 32'hFF);
    wr(32'h7DC, 32'hFF);
    check("out_port_nohit", out_port, 32'h00A5_0000);

    // input synchroniser latency
    in_port = 32'h0000_3C00;
    rd("in_ch1_edge0", 32'h7E4, 32'h0);
    tick();
    rd("in_ch1_edge1", 32'h7E4, 32'h0);
    tick();
    rd("in_ch1_edge2", 32'h7E4, 32'h3C);
    rd("in_ch0", 32'h7E0, 32'h0);
    addr = 32'h7FC; re = 1'b1;
    #1;
    check("hit_7fc", {31'h0, hit}, 32'h0);
    check("rdata_7fc", rdata, 32'h0);
    addr = 32'h7F8;
    #1;
    check("hit_7f8", {31'h0, hit}, 32'h1);
    re = 1'b0;
    addr = 32'h7E4;
    #1;
    check("rdata_no_re", rdata, 32'h0);

    // rising edge on channel 1 with IRQ_EN[1]
    wr(32'h7F0, 32'h2);
    rd("irq_en_rd", 32'h7F0, 32'h2);
    irq_src = 4'b0010;
    tick();
    tick();
    rd("stat_before_e3", 32'h7F4, 32'h0);
    check("irq_before_e3", {31'h0, irq}, 32'h0);
    tick();
    rd("stat_after_e3", 32'h7F4, 32'h2);
    check("irq_after_e3", {31'h0, irq}, 32'h1);
    wr(32'h7F4, 32'h2);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd("stat_after_w1c", 32'h7F4, 32'h0);

    // falling-edge mode on channel 0
    wr(32'h7F8, 32'h1);
    rd("edge_mode_rd", 32'h7F8, 32'h1);
    irq_src = 4'b0011;
    tick(); tick(); tick(); tick();
    rd("fall_mode_rise", 32'h7F4, 32'h0);
    irq_src = 4'b0010;
    tick(); tick(); tick();
    rd("fall_mode_fall", 32'h7F4, 32'h1);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(32'h7F4, 32'h1);
    rd("stat_clr0", 32'h7F4, 32'h0);

    // clear and set of bit 3 on the same edge
    irq_src = 4'b1010;
    tick();
    tick();
    wr(32'h7F4, 32'h8);
    rd("set_wins", 32'h7F4, 32'h8);
    wr(32'h7F0, 32'h8);
    check("irq_en3", {31'h0, irq}, 32'h1);

    // reset mid-transfer clears everything immediately
    irq_src = 4'hF;
    addr = 32'h7E0; wdata = 32'h77; we = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("rst_out_port", out_port, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    rd("seed_no_evt", 32'h7F4, 32'h0);
    rd("rst_irq_en", 32'h7F0, 32'h0);
    rd("rst_edge_mode", 32'h7F8, 32'h0);
    check("rst_out_after", out_port, 32'h0);

    // detection still works after seeding
    irq_src = 4'hB;
    tick(); tick(); tick();
    rd("ch2_fall_rise_mode", 32'h7F4, 32'h0);
    irq_src = 4'hF;
    tick(); tick(); tick();
    rd("ch2_rise", 32'h7F4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
